// File: rtl/dds_cmd_pkg.sv
// dds_cmd_pkg: shared constants and types for the DDS command controller.
// Holds the frame header, the response bytes, the command codes, the parser
// state encoding and a helper that tells whether a command code is known.
package dds_cmd_pkg;

  localparam logic [7:0] HDR = 8'hA5;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  localparam logic [7:0] CMD_FREQ  = 8'h01;
  localparam logic [7:0] CMD_PHASE = 8'h02;
  localparam logic [7:0] CMD_AMP   = 8'h03;
  localparam logic [7:0] CMD_OEN   = 8'h04;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DATA,
    CHK,
    APPLY
  } state_t;

  function automatic logic cmd_known(input logic [7:0] code);
    return (code == CMD_FREQ) || (code == CMD_PHASE) ||
           (code == CMD_AMP)  || (code == CMD_OEN);
  endfunction

endpackage

// File: rtl/dds_cmd_resp_tx.sv
// dds_cmd_resp_tx: single-entry response holder in front of the UART
// transmitter. A queued byte is presented on tx_data with tx_en_sig held high
// until tx_done_sig. A byte queued while another is in flight is dropped,
// unless the in-flight byte completes in that same cycle.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   queue         one-cycle request to send queue_data
//   queue_data    response byte to send
//   tx_done_sig   transmitter finished the current byte
//   tx_en_sig     transmit request, held until tx_done_sig
//   tx_data       byte being transmitted
module dds_cmd_resp_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       queue,
  input  logic [7:0] queue_data,
  input  logic       tx_done_sig,
  output logic       tx_en_sig,
  output logic [7:0] tx_data
);

  // The slot is free either when idle or when its byte finishes this cycle.
  logic slot_free;
  assign slot_free = !tx_en_sig || tx_done_sig;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_en_sig <= 1'b0;
      tx_data   <= 8'h00;
    end else if (queue && slot_free) begin
      tx_en_sig <= 1'b1;
      tx_data   <= queue_data;
    end else if (tx_done_sig) begin
      tx_en_sig <= 1'b0;
    end
  end

endmodule

// File: rtl/dds_cmd_controller.sv
// dds_cmd_controller: framed UART command decoder for the DDS core.
// Frames are A5, CMD, D3, D2, D1, D0, CHK with CHK = CMD^D3^D2^D1^D0.
// A good frame with a known command writes one config register, pulses
// cfg_update and answers ACK; a bad frame answers NAK and bumps err_cnt.
// A frame stalled too long between bytes is abandoned silently (err_cnt++).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rx_data, rx_done_sig     received byte and its one-cycle strobe
//   tx_done_sig              transmitter finished a byte
//   tx_en_sig, tx_data       response request and byte
//   fre_word, pha_word       DDS frequency / phase words
//   amp_word, out_en         DDS amplitude scale / output enable
//   cfg_update               pulse in the cycle a config register changes
//   err_cnt                  saturating count of rejected/timed-out frames
module dds_cmd_controller
  import dds_cmd_pkg::*;
#(
  parameter logic [31:0] FREQ_DEFAULT   = 32'd28633115,
  parameter logic [9:0]  AMP_DEFAULT    = 10'h3FF,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done_sig,
  input  logic        tx_done_sig,
  output logic        tx_en_sig,
  output logic [7:0]  tx_data,
  output logic [31:0] fre_word,
  output logic [31:0] pha_word,
  output logic [9:0]  amp_word,
  output logic        out_en,
  output logic        cfg_update,
  output logic [7:0]  err_cnt
);

  state_t      state, state_nxt;
  logic [7:0]  cmd_q;
  logic [7:0]  chk_acc;
  logic [31:0] payload;
  logic [1:0]  idx;
  logic        chk_ok;
  logic [31:0] idle_cnt;
  logic        idle_expired;
  logic        timeout;
  logic        apply_ok;
  logic        apply_fail;

  assign idle_expired = (idle_cnt == TIMEOUT_CYCLES - 32'd1);

  // NOTE: state and data registers use non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    timeout    = 1'b0;
    apply_ok   = 1'b0;
    apply_fail = 1'b0;
    case (state)
      IDLE: begin
        if (rx_done_sig && rx_data == HDR) state_nxt = CMD;
      end
      CMD, DATA, CHK: begin
        if (rx_done_sig) begin
          if (state == CMD)                  state_nxt = DATA;
          else if (state == DATA && idx == 2'd0) state_nxt = CHK;
          else if (state == CHK)             state_nxt = APPLY;
        end else if (idle_expired) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      APPLY: begin
        // Any byte arriving here is ignored; the frame is decided already.
        state_nxt = IDLE;
        if (chk_ok && cmd_known(cmd_q)) apply_ok   = 1'b1;
        else                            apply_fail = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame capture and inter-byte idle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q    <= 8'h00;
      chk_acc  <= 8'h00;
      payload  <= 32'h0;
      idx      <= 2'd0;
      chk_ok   <= 1'b0;
      idle_cnt <= 32'h0;
    end else begin
      if (rx_done_sig || state == IDLE) idle_cnt <= 32'h0;
      else                              idle_cnt <= idle_cnt + 32'd1;

      if (rx_done_sig) begin
        case (state)
          CMD: begin
            cmd_q   <= rx_data;
            chk_acc <= rx_data;
            idx     <= 2'd3;
          end
          DATA: begin
            // Bytes arrive MSB first, so shifting left assembles D3..D0.
            payload <= {payload[23:0], rx_data};
            chk_acc <= chk_acc ^ rx_data;
            idx     <= idx - 2'd1;
          end
          CHK:     chk_ok <= (rx_data == chk_acc);
          default: ;
        endcase
      end
    end
  end

  // Configuration registers and error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      fre_word   <= FREQ_DEFAULT;
      pha_word   <= 32'h0;
      amp_word   <= AMP_DEFAULT;
      out_en     <= 1'b1;
      cfg_update <= 1'b0;
      err_cnt    <= 8'h00;
    end else begin
      cfg_update <= apply_ok;
      if (apply_ok) begin
        case (cmd_q)
          CMD_FREQ:  fre_word <= payload;
          CMD_PHASE: pha_word <= payload;
          CMD_AMP:   amp_word <= payload[9:0];
          CMD_OEN:   out_en   <= payload[0];
          default:   ;
        endcase
      end
      if ((apply_fail || timeout) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  dds_cmd_resp_tx u_resp_tx (
    .clk         (clk),
    .rst         (rst),
    .queue       (apply_ok || apply_fail),
    .queue_data  (apply_ok ? ACK : NAK),
    .tx_done_sig (tx_done_sig),
    .tx_en_sig   (tx_en_sig),
    .tx_data     (tx_data)
  );

endmodule

// File: tb/tb_dds_cmd_controller.sv
// Scoreboard bench for dds_cmd_controller: stimulus pushes the expected
// response byte, a monitor pops and compares on every new tx_en_sig.
module tb_dds_cmd_controller;

  localparam logic [31:0] FREQ_DEF = 32'd28633115;
  localparam int          TMO      = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done_sig = 1'b0;
  logic        tx_done_sig = 1'b0;
  logic        tx_en_sig;
  logic [7:0]  tx_data;
  logic [31:0] fre_word, pha_word;
  logic [9:0]  amp_word;
  logic        out_en, cfg_update;
  logic [7:0]  err_cnt;

  dds_cmd_controller #(
    .FREQ_DEFAULT   (FREQ_DEF),
    .AMP_DEFAULT    (10'h3FF),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_done_sig (rx_done_sig),
    .tx_done_sig (tx_done_sig),
    .tx_en_sig   (tx_en_sig),
    .tx_data     (tx_data),
    .fre_word    (fre_word),
    .pha_word    (pha_word),
    .amp_word    (amp_word),
    .out_en      (out_en),
    .cfg_update  (cfg_update),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  bit         hold_tx = 1'b0;
  int         cfg_pulses = 0;
  logic       tx_en_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every fresh response is compared with the oldest expected one.
  always @(negedge clk) begin
    if (tx_en_sig && !tx_en_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got 0x%0h expected no response", tx_data);
      end else begin
        check("resp_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
      end
    end
    if (cfg_update) cfg_pulses++;
    tx_en_prev = tx_en_sig;
  end

  // Transmitter model: finishes a byte a few cycles after it is requested.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_en_sig && !hold_tx) begin
        repeat (3) @(negedge clk);
        tx_done_sig = 1'b1;
        @(negedge clk);
        tx_done_sig = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data     = b;
    rx_done_sig = 1'b1;
    @(negedge clk);
    rx_done_sig = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] d, input logic [7:0] chk);
    send_byte(8'hA5);
    send_byte(cmd);
    send_byte(d[31:24]);
    send_byte(d[23:16]);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
    send_byte(chk);
    repeat (4) @(negedge clk);
  endtask

  int p0;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    check("rst_fre", fre_word, FREQ_DEF);
    check("rst_pha", pha_word, 32'h0);
    check("rst_amp", {22'h0, amp_word}, 32'h3FF);
    check("rst_oen", {31'h0, out_en}, 32'h1);
    check("rst_cfg", {31'h0, cfg_update}, 32'h0);
    check("rst_txen", {31'h0, tx_en_sig}, 32'h0);
    check("rst_txdata", {24'h0, tx_data}, 32'h0);
    check("rst_err", {24'h0, err_cnt}, 32'h0);

    // Corrupted checksum: NAK, no change.
    p0 = cfg_pulses;
    exp_q.push_back(8'h15);
    send_frame(8'h01, 32'h12345678, 8'h00);
    check("badchk_fre", fre_word, FREQ_DEF);
    check("badchk_err", {24'h0, err_cnt}, 32'd1);
    check("badchk_pulses", cfg_pulses - p0, 32'd0);

    // Good frequency frame with exact latency check; CHK = 0x09.
    p0 = cfg_pulses;
    exp_q.push_back(8'h06);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    @(negedge clk);
    rx_data     = 8'h09;
    rx_done_sig = 1'b1;
    @(negedge clk);
    rx_done_sig = 1'b0;
    check("lat_fre_n1", fre_word, FREQ_DEF);
    check("lat_cfg_n1", {31'h0, cfg_update}, 32'h0);
    @(negedge clk);
    check("lat_fre_n2", fre_word, 32'h12345678);
    check("lat_cfg_n2", {31'h0, cfg_update}, 32'h1);
    check("lat_txen_n2", {31'h0, tx_en_sig}, 32'h1);
    @(negedge clk);
    check("lat_cfg_n3", {31'h0, cfg_update}, 32'h0);
    repeat (10) @(negedge clk);
    check("freq_pulses", cfg_pulses - p0, 32'd1);

    // Stray bytes in IDLE are discarded silently.
    send_byte(8'h33);
    send_byte(8'h00);
    repeat (4) @(negedge clk);
    check("stray_err", {24'h0, err_cnt}, 32'd1);

    // Unknown command with correct checksum: NAK.
    exp_q.push_back(8'h15);
    send_frame(8'h07, 32'h0, 8'h07);
    check("badcmd_err", {24'h0, err_cnt}, 32'd2);
    check("badcmd_fre", fre_word, 32'h12345678);

    // 0xA5 inside a frame is payload; CHK = 0x01.
    exp_q.push_back(8'h06);
    send_frame(8'h01, 32'hA5A5A5A5, 8'h01);
    check("a5_data_fre", fre_word, 32'hA5A5A5A5);

    // Timeout mid-frame, then a valid amplitude frame (CHK = 0x54).
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h12);
    repeat (TMO + 10) @(negedge clk);
    check("tmo_err", {24'h0, err_cnt}, 32'd3);
    exp_q.push_back(8'h06);
    send_frame(8'h03, 32'h00000255, 8'h54);
    check("amp_word", {22'h0, amp_word}, 32'h255);

    // Reset mid-frame.
    repeat (20) @(negedge clk);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'hAA);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rstmid_pha", pha_word, 32'h0);
    check("rstmid_fre", fre_word, FREQ_DEF);
    check("rstmid_amp", {22'h0, amp_word}, 32'h3FF);
    check("rstmid_err", {24'h0, err_cnt}, 32'd0);
    check("rstmid_txen", {31'h0, tx_en_sig}, 32'h0);
    exp_q.push_back(8'h06);
    send_frame(8'h02, 32'hDEADBEEF, 8'h20);
    check("pha_word", pha_word, 32'hDEADBEEF);

    // Back-to-back frames with the transmitter stalled.
    repeat (10) @(negedge clk);
    p0 = cfg_pulses;
    hold_tx = 1'b1;
    exp_q.push_back(8'h06);
    send_frame(8'h04, 32'h0, 8'h04);
    send_frame(8'h01, 32'h0000ABCD, 8'h67);
    check("hold_txen", {31'h0, tx_en_sig}, 32'h1);
    check("hold_txdata", {24'h0, tx_data}, 32'h06);
    check("hold_oen", {31'h0, out_en}, 32'h0);
    check("hold_fre", fre_word, 32'h0000ABCD);
    check("hold_pulses", cfg_pulses - p0, 32'd2);
    hold_tx = 1'b0;
    repeat (20) @(negedge clk);

    // err_cnt saturation.
    for (int i = 0; i < 260; i++) begin
      exp_q.push_back(8'h15);
      send_frame(8'h01, 32'h0, 8'hFF);
    end
    check("err_sat", {24'h0, err_cnt}, 32'd255);

    // Drain outstanding responses (bounded).
    for (int i = 0; i < 200 && (exp_q.size() != 0 || tx_en_sig); i++) @(negedge clk);
    check("resp_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
